// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared definitions for the UART command packet controller.
// Holds the FSM state encoding, the error codes reported on err_code,
// the default packet start marker and a buffer address-width helper.
package uart_cmd_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR    = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CHK     = 3'd4;
  localparam logic [2:0] ST_COMMIT  = 3'd5;

  // Error causes reported with pkt_err
  localparam logic [2:0] ERR_CHK     = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;

  // Default packet start marker
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Address width for a buffer of the given depth (at least one bit)
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// uart_cmd_buf: payload staging buffer for uart_cmd_ctrl.
// DEPTH x 8 storage, synchronous write, combinational read so the commit
// sequencer can present buffer[i] on the same edge it issues write i.
module uart_cmd_buf
  import uart_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Store one payload byte per accepted receiver strobe
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: frames UART receiver bytes as SYNC/ADDR/LEN/payload/CHK
// packets, verifies the XOR checksum and commits good payloads to the
// register bus one write per cycle. Bad, oversized or stalled packets are
// discarded with pkt_err and a cause on err_code.
// Optional feature macro: UART_CMD_STATS_EN builds saturating ok/err
// packet counters; without it ok_count and err_count are tied to zero.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 12000000,
  parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 36000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic [2:0]  err_code,
  output logic        busy,
  output logic [15:0] ok_count,
  output logic [15:0] err_count
);

  localparam int unsigned AW        = addr_width(MAX_LEN);
  localparam int unsigned TMO_W     = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  // Firing when the counter is about to reach TIMEOUT_CLKS-1 puts pkt_err
  // exactly TIMEOUT_CLKS cycles after the last accepted byte.
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 2);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  // CLK_FREQ only documents how the TIMEOUT_CLKS default was chosen
  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 2 || CLK_FREQ == 0) begin : g_bad_cfg
    $error("uart_cmd_ctrl: MAX_LEN must be 1..255, TIMEOUT_CLKS >= 2, CLK_FREQ > 0");
  end

  logic [2:0]       state;
  logic [7:0]       idx;
  logic [TMO_W-1:0] tmo_cnt;
  logic [7:0]       addr_q;
  logic [7:0]       len_q;
  logic [7:0]       chk_acc;
  logic [7:0]       rd_data;
  logic             buf_we;

  assign buf_we = rx_done && (state == ST_PAYLOAD);

  uart_cmd_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx[AW-1:0]),
    .wdata (rx_data),
    .raddr (idx[AW-1:0]),
    .rdata (rd_data)
  );

  // Packet header and checksum accumulation (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (rx_done) begin
      case (state)
        ST_ADDR: begin
          addr_q  <= rx_data;
          chk_acc <= rx_data;
        end
        ST_LEN: begin
          len_q   <= rx_data;
          chk_acc <= chk_acc ^ rx_data;
        end
        ST_PAYLOAD: chk_acc <= chk_acc ^ rx_data;
        default: ;
      endcase
    end
  end

  // Packet sequencer: framing, timeout, checksum verdict and commit drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      tmo_cnt  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      pkt_ok   <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= '0;
      busy     <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      pkt_ok  <= 1'b0;
      pkt_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_done && rx_data == SYNC_BYTE) begin
            state   <= ST_ADDR;
            busy    <= 1'b1;
            tmo_cnt <= '0;
          end
        end
        ST_ADDR, ST_LEN, ST_PAYLOAD, ST_CHK: begin
          if (rx_done) begin
            // An arriving byte always beats a timeout expiring this cycle
            tmo_cnt <= '0;
            case (state)
              ST_ADDR: state <= ST_LEN;
              ST_LEN: begin
                if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                  pkt_err  <= 1'b1;
                  err_code <= ERR_LEN;
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
                end else begin
                  idx   <= '0;
                  state <= ST_PAYLOAD;
                end
              end
              ST_PAYLOAD: begin
                if (idx == len_q - 8'd1) begin
                  idx   <= '0;
                  state <= ST_CHK;
                end else begin
                  idx <= idx + 8'd1;
                end
              end
              default: begin
                if (rx_data == chk_acc) begin
                  // First write issues on the verdict edge so the burst
                  // occupies exactly LEN cycles starting right after CHK.
                  wr_en   <= 1'b1;
                  wr_addr <= addr_q;
                  wr_data <= rd_data;
                  idx     <= 8'd1;
                  if (len_q == 8'd1) begin
                    pkt_ok <= 1'b1;
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                  end else begin
                    state <= ST_COMMIT;
                  end
                end else begin
                  pkt_err  <= 1'b1;
                  err_code <= ERR_CHK;
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
                end
              end
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            pkt_err  <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_COMMIT: begin
          wr_en   <= 1'b1;
          wr_addr <= addr_q + idx;
          wr_data <= rd_data;
          idx     <= idx + 8'd1;
          if (idx == len_q - 8'd1) begin
            pkt_ok <= 1'b1;
            state  <= ST_IDLE;
            busy   <= 1'b0;
          end
          // A byte during the drain is dropped; the commit still finishes
          if (rx_done) begin
            pkt_err  <= 1'b1;
            err_code <= ERR_OVERRUN;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_CMD_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating packet statistics driven by the registered status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_count  <= '0;
      err_count <= '0;
    end else begin
      if (pkt_ok) begin
        ok_count <= sat_inc(ok_count);
      end
      if (pkt_err) begin
        err_count <= sat_inc(err_count);
      end
    end
  end
`else
  assign ok_count  = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed, scoreboarded bench for uart_cmd_ctrl.
// Expected writes and error codes are queued as packets are sent and
// retired by a negedge monitor; cycle-exact points are checked inline.
module tb_uart_cmd_ctrl;
  import uart_cmd_pkg::*;

  localparam int unsigned TMO = 40;
  localparam int unsigned MAXL = 16;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
    logic       last;
  } wr_t;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        pkt_ok;
  logic        pkt_err;
  logic [2:0]  err_code;
  logic        busy;
  logic [15:0] ok_count;
  logic [15:0] err_count;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_ok = 0;
  int exp_errs = 0;
  wr_t exp_wr[$];
  logic [2:0] exp_err[$];
  logic [7:0] pl [0:15];
  wr_t mon_e;
  logic [2:0] mon_c;

  uart_cmd_ctrl #(
    .CLK_FREQ     (12000000),
    .SYNC_BYTE    (8'hA5),
    .MAX_LEN      (MAXL),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pkt_ok    (pkt_ok),
    .pkt_err   (pkt_err),
    .err_code  (err_code),
    .busy      (busy),
    .ok_count  (ok_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int stat(input int v);
`ifdef UART_CMD_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic push_err(input logic [2:0] c);
    exp_err.push_back(c);
    exp_errs++;
  endtask

  // Sends SYNC/ADDR/LEN/pl[0..len-1]/CHK and queues what the DUT must do.
  // Returns right after the edge that processed the CHK byte.
  task automatic send_pkt(input logic [7:0] addr, input int len, input bit corrupt, input int sync_gap);
    logic [7:0] chk;
    wr_t e;
    chk = addr ^ 8'(len);
    for (int i = 0; i < len; i++) chk = chk ^ pl[i];
    if (corrupt) begin
      chk = chk ^ 8'h01;
      push_err(ERR_CHK);
    end else begin
      for (int i = 0; i < len; i++) begin
        e.a = addr + 8'(i);
        e.d = pl[i];
        e.last = (i == len - 1);
        exp_wr.push_back(e);
      end
      exp_ok++;
    end
    send_byte(8'hA5);
    idle(sync_gap);
    send_byte(addr);
    send_byte(8'(len));
    for (int i = 0; i < len; i++) send_byte(pl[i]);
    send_byte(chk);
  endtask

  // Scoreboard monitor: retires queued writes and error codes
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_wr", wr_en, 1'b0);
      end else begin
        mon_e = exp_wr.pop_front();
        check("wr_addr", wr_addr, mon_e.a);
        check("wr_data", wr_data, mon_e.d);
        check("pkt_ok_on_wr", pkt_ok, mon_e.last);
      end
    end else if (pkt_ok) begin
      check("pkt_ok_without_wr", pkt_ok, 1'b0);
    end
    if (pkt_err) begin
      if (exp_err.size() == 0) begin
        check("unexpected_err", pkt_err, 1'b0);
      end else begin
        mon_c = exp_err.pop_front();
        check("err_code", err_code, mon_c);
      end
    end
  end

  initial begin
    rst = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    idle(3);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_pkt_ok", pkt_ok, 0);
    check("rst_pkt_err", pkt_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_busy", busy, 0);
    check("rst_ok_count", ok_count, 0);
    check("rst_err_count", err_count, 0);
    rst = 1'b0;
    idle(2);

    // Non-sync byte in IDLE is ignored
    send_byte(8'h3C);
    check("junk_busy", busy, 0);
    idle(2);

    // Good packet A5 10 02 11 22 21
    pl[0] = 8'h11; pl[1] = 8'h22;
    send_pkt(8'h10, 2, 1'b0, 0);
    check("good_wr_en_n1", wr_en, 1);
    check("good_busy_commit", busy, 1);
    check("good_no_ok_n1", pkt_ok, 0);
    idle(1);
    check("good_pkt_ok_n2", pkt_ok, 1);
    idle(1);
    check("good_wr_en_done", wr_en, 0);
    check("good_busy_done", busy, 0);
    idle(2);

    // Same packet with CHK 0x20
    send_pkt(8'h10, 2, 1'b1, 0);
    check("badchk_pkt_err", pkt_err, 1);
    check("badchk_code", err_code, ERR_CHK);
    check("badchk_no_wr", wr_en, 0);
    idle(3);
    check("err_code_holds", err_code, ERR_CHK);

    // LEN 0 and LEN 17
    push_err(ERR_LEN);
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00);
    check("len0_pkt_err", pkt_err, 1);
    check("len0_code", err_code, ERR_LEN);
    idle(3);
    push_err(ERR_LEN);
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h11);
    check("len17_pkt_err", pkt_err, 1);
    check("len17_code", err_code, ERR_LEN);
    check("len17_busy", busy, 0);
    idle(3);

    // Timeout: A5 10 02 11 then silence
    push_err(ERR_TIMEOUT);
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11);
    idle(TMO - 2);
    check("tmo_not_early", pkt_err, 0);
    idle(1);
    check("tmo_pkt_err", pkt_err, 1);
    check("tmo_code", err_code, ERR_TIMEOUT);
    idle(3);

    // Good packet after timeout commits normally
    pl[0] = 8'h11; pl[1] = 8'h22;
    send_pkt(8'h10, 2, 1'b0, 0);
    idle(4);

    // Byte landing on the expiry edge wins over the timeout
    pl[0] = 8'h5A;
    send_pkt(8'h20, 1, 1'b0, TMO - 2);
    check("edge_wr_en", wr_en, 1);
    check("edge_pkt_ok", pkt_ok, 1);
    idle(3);

    // Address wrap
    pl[0] = 8'hAA; pl[1] = 8'hBB;
    send_pkt(8'hFF, 2, 1'b0, 0);
    idle(4);

    // Overrun coinciding with the final write of a 4-byte commit
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
    send_pkt(8'h40, 4, 1'b0, 0);
    push_err(ERR_OVERRUN);
    idle(2);
    send_byte(8'hA5);
    check("ovr_pkt_ok", pkt_ok, 1);
    check("ovr_pkt_err", pkt_err, 1);
    check("ovr_code", err_code, ERR_OVERRUN);
    check("ovr_busy", busy, 0);
    idle(3);
    check("stats_ok", ok_count, stat(exp_ok));
    check("stats_err", err_count, stat(exp_errs));

    // Reset during commit of a 4-byte packet
    pl[0] = 8'hC1; pl[1] = 8'hC2; pl[2] = 8'hC3; pl[3] = 8'hC4;
    send_pkt(8'h60, 4, 1'b0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    exp_wr.delete();
    exp_err.delete();
    exp_ok = 0;
    exp_errs = 0;
    #1;
    check("rst_commit_wr_en", wr_en, 0);
    idle(3);
    rst = 1'b0;
    idle(6);
    check("post_rst_busy", busy, 0);
    check("post_rst_ok_count", ok_count, 0);
    check("post_rst_err_count", err_count, 0);

    // Recovery packet after reset
    pl[0] = 8'h77;
    send_pkt(8'h70, 1, 1'b0, 0);
    idle(3);
    check("final_ok_count", ok_count, stat(exp_ok));
    check("final_err_count", err_count, stat(exp_errs));
    check("wr_queue_drained", exp_wr.size(), 0);
    check("err_queue_drained", exp_err.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
